iob_native2iob_split: RTL and testbench

Parametrised bridge between a PicoRV32-style native memory port and IOb master buses: one instruction bus plus `N_DBUS` data buses selected by address MSBs. Request path and CPU response path are registered. A per-transaction FSM holds `valid` until `ready`, then waits for `rvalid` on reads. A watchdog aborts stalled transactions. Sits between the CPU core and the system interconnect inside the CPU wrapper; it replaces the combinational ibus/dbus split.

---
 rtl/iob_native2iob_split_pkg.sv | 19 +
 rtl/iob_native2iob_watchdog.sv | 39 +++
 rtl/iob_native2iob_split.sv | 207 ++++++++++++++++++++
 tb/tb_iob_native2iob_split.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/iob_native2iob_split_pkg.sv
// Shared definitions for the native-to-IOb split bridge: FSM state encoding,
// the error read-data fill value and the data-channel select width helper.
package iob_native2iob_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Replicated across DATA_W to form the rdata returned on timeout or bad channel.
    localparam logic ERR_RDATA_BIT = 1'b1;

    function automatic int sel_width(input int n_dbus);
        return (n_dbus > 1) ? $clog2(n_dbus) : 1;
    endfunction

endpackage

// File: rtl/iob_native2iob_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count is about to reach all ones.
module iob_native2iob_watchdog #(
    parameter int TIMEOUT_W = 12
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic cke_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_W-1:0] LAST_CNT = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    // Fires so that the count lands on all ones on the same edge the FSM aborts,
    // i.e. 2^TIMEOUT_W-1 enabled cycles after the clear.
    assign expire_o = en_i && !clr_i && (cnt_q == LAST_CNT);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else if (cke_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iob_native2iob_split.sv
// Registered bridge from a PicoRV32-style native port to one IOb instruction bus
// and N_DBUS IOb data buses selected by address MSBs, with a stall watchdog.
module iob_native2iob_split
    import iob_native2iob_split_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int N_DBUS     = 2,
    parameter int USE_EXTMEM = 0,
    parameter int TIMEOUT_W  = 12
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic                         cke_i,
    input  logic                         boot_i,
    output logic                         err_o,
    input  logic                         cpu_valid_i,
    input  logic                         cpu_instr_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [DATA_W-1:0]            cpu_wdata_i,
    input  logic [DATA_W/8-1:0]          cpu_wstrb_i,
    output logic [DATA_W-1:0]            cpu_rdata_o,
    output logic                         cpu_ready_o,
    output logic                         ibus_iob_valid_o,
    output logic [ADDR_W-1:0]            ibus_iob_addr_o,
    output logic [DATA_W-1:0]            ibus_iob_wdata_o,
    output logic [DATA_W/8-1:0]          ibus_iob_wstrb_o,
    input  logic                         ibus_iob_rvalid_i,
    input  logic [DATA_W-1:0]            ibus_iob_rdata_i,
    input  logic                         ibus_iob_ready_i,
    output logic [N_DBUS-1:0]            dbus_iob_valid_o,
    output logic [N_DBUS*ADDR_W-1:0]     dbus_iob_addr_o,
    output logic [N_DBUS*DATA_W-1:0]     dbus_iob_wdata_o,
    output logic [N_DBUS*DATA_W/8-1:0]   dbus_iob_wstrb_o,
    input  logic [N_DBUS-1:0]            dbus_iob_rvalid_i,
    input  logic [N_DBUS*DATA_W-1:0]     dbus_iob_rdata_i,
    input  logic [N_DBUS-1:0]            dbus_iob_ready_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = sel_width(N_DBUS);
    localparam int PAD_N  = 1 << SEL_W;
    localparam logic [DATA_W-1:0] ERR_RDATA = {DATA_W{ERR_RDATA_BIT}};

    state_t              state_q, state_d;
    logic                instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                ibus_valid_q, ibus_valid_d;
    logic [N_DBUS-1:0]   dbus_valid_q, dbus_valid_d;

    logic                wd_clr, wd_en, wd_expire;
    logic [SEL_W-1:0]    req_sel;
    logic                req_bad;
    logic [ADDR_W-1:0]   req_addr;
    logic                is_write;
    logic                tgt_ready, tgt_rvalid;
    logic [DATA_W-1:0]   tgt_rdata;

    // Response inputs padded to a power of two so sel_q always indexes in range.
    logic [PAD_N-1:0]    dbus_ready_pad, dbus_rvalid_pad;
    logic [DATA_W-1:0]   dbus_rdata_arr [PAD_N];

    assign dbus_ready_pad  = PAD_N'(dbus_iob_ready_i);
    assign dbus_rvalid_pad = PAD_N'(dbus_iob_rvalid_i);

    for (genvar k = 0; k < PAD_N; k++) begin : g_rdata
        if (k < N_DBUS) begin : g_used
            assign dbus_rdata_arr[k] = dbus_iob_rdata_i[k*DATA_W +: DATA_W];
        end else begin : g_pad
            assign dbus_rdata_arr[k] = '0;
        end
    end

    assign req_sel  = cpu_addr_i[ADDR_W-1 -: SEL_W];
    assign req_bad  = !cpu_instr_i && ({1'b0, req_sel} >= (SEL_W+1)'(N_DBUS));
    assign req_addr = (USE_EXTMEM != 0 && cpu_instr_i)
                    ? {~boot_i, cpu_addr_i[ADDR_W-2:0]} : cpu_addr_i;

    assign is_write   = !instr_q && (|wstrb_q);
    assign tgt_ready  = instr_q ? ibus_iob_ready_i  : dbus_ready_pad[sel_q];
    assign tgt_rvalid = instr_q ? ibus_iob_rvalid_i : dbus_rvalid_pad[sel_q];
    assign tgt_rdata  = instr_q ? ibus_iob_rdata_i  : dbus_rdata_arr[sel_q];

    iob_native2iob_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block infers a latch.
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_valid_i) begin
                    instr_d = cpu_instr_i;
                    addr_d  = req_addr;
                    wdata_d = cpu_wdata_i;
                    wstrb_d = cpu_wstrb_i;
                    sel_d   = req_sel;
                    if (req_bad) begin
                        state_d = ST_DONE;
                        rdata_d = ERR_RDATA;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        wd_clr  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                wd_en = 1'b1;
                if (wd_expire) begin
                    state_d = ST_DONE;
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                end else if (tgt_ready) begin
                    state_d = is_write ? ST_DONE : ST_RESP;
                end
            end
            ST_RESP: begin
                wd_en = 1'b1;
                if (wd_expire) begin
                    state_d = ST_DONE;
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                end else if (tgt_rvalid) begin
                    state_d = ST_DONE;
                    rdata_d = tgt_rdata;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus-facing strobes follow the next state so they leave the flops glitch-free.
        ibus_valid_d = (state_d == ST_REQ) && instr_d;
        dbus_valid_d = (state_d == ST_REQ && !instr_d) ? (N_DBUS'(1) << sel_d) : '0;
        cpu_ready_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        // NOTE: every register, data included, is reset so all outputs read 0 out of reset.
        if (!arst_n_i) begin
            state_q      <= ST_IDLE;
            instr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            sel_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cpu_ready_q  <= 1'b0;
            ibus_valid_q <= 1'b0;
            dbus_valid_q <= '0;
        end else if (cke_i) begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q      <= state_d;
            instr_q      <= instr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            sel_q        <= sel_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cpu_ready_q  <= cpu_ready_d;
            ibus_valid_q <= ibus_valid_d;
            dbus_valid_q <= dbus_valid_d;
        end
    end

    assign err_o            = err_q;
    assign cpu_rdata_o      = rdata_q;
    assign cpu_ready_o      = cpu_ready_q;
    assign ibus_iob_valid_o = ibus_valid_q;
    assign ibus_iob_addr_o  = addr_q;
    assign ibus_iob_wdata_o = '0;
    assign ibus_iob_wstrb_o = '0;
    assign dbus_iob_valid_o = dbus_valid_q;
    assign dbus_iob_addr_o  = {N_DBUS{addr_q}};
    assign dbus_iob_wdata_o = {N_DBUS{wdata_q}};
    assign dbus_iob_wstrb_o = {N_DBUS{wstrb_q}};

endmodule

// File: tb/tb_iob_native2iob_split.sv
// Self-checking bench for iob_native2iob_split (N_DBUS=3, USE_EXTMEM=1, TIMEOUT_W=4):
// directed corner cases followed by randomized transactions against a cycle-count model.
module tb_iob_native2iob_split;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ND = 3;
    localparam int TO = 15;  // 2^TIMEOUT_W - 1

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            cke = 1'b1;
    logic            boot = 1'b0;
    logic            err;
    logic            cpu_valid = 1'b0;
    logic            cpu_instr = 1'b0;
    logic [AW-1:0]   cpu_addr = '0;
    logic [DW-1:0]   cpu_wdata = '0;
    logic [3:0]      cpu_wstrb = '0;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_ready;
    logic            ibus_valid;
    logic [AW-1:0]   ibus_addr;
    logic [DW-1:0]   ibus_wdata;
    logic [3:0]      ibus_wstrb;
    logic            ibus_rvalid = 1'b0;
    logic [DW-1:0]   ibus_rdata = '0;
    logic            ibus_ready = 1'b0;
    logic [ND-1:0]   dbus_valid;
    logic [ND*AW-1:0] dbus_addr;
    logic [ND*DW-1:0] dbus_wdata;
    logic [ND*4-1:0] dbus_wstrb;
    logic [ND-1:0]   dbus_rvalid = '0;
    logic [ND*DW-1:0] dbus_rdata = '0;
    logic [ND-1:0]   dbus_ready = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_rdata = '0;
    logic          m_err   = 1'b0;

    iob_native2iob_split #(
        .ADDR_W(AW), .DATA_W(DW), .N_DBUS(ND), .USE_EXTMEM(1), .TIMEOUT_W(4)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .boot_i(boot), .err_o(err),
        .cpu_valid_i(cpu_valid), .cpu_instr_i(cpu_instr), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_wstrb_i(cpu_wstrb),
        .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
        .ibus_iob_valid_o(ibus_valid), .ibus_iob_addr_o(ibus_addr),
        .ibus_iob_wdata_o(ibus_wdata), .ibus_iob_wstrb_o(ibus_wstrb),
        .ibus_iob_rvalid_i(ibus_rvalid), .ibus_iob_rdata_i(ibus_rdata),
        .ibus_iob_ready_i(ibus_ready),
        .dbus_iob_valid_o(dbus_valid), .dbus_iob_addr_o(dbus_addr),
        .dbus_iob_wdata_o(dbus_wdata), .dbus_iob_wstrb_o(dbus_wstrb),
        .dbus_iob_rvalid_i(dbus_rvalid), .dbus_iob_rdata_i(dbus_rdata),
        .dbus_iob_ready_i(dbus_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One native transaction. r = cycles target ready stays low, v = cycles between
    // ready and rvalid. spur injects an rvalid during REQ; hold freezes cke in RESP.
    task automatic run_txn(input logic instr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [3:0] wstrb,
                           input int r, input int v, input logic [DW-1:0] resp,
                           input logic spur, input logic hold);
        int            ch, total, vend, done_c;
        logic          bad, is_wr, tmo, rv;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] prev_rdata, rdv;

        ch    = int'(addr[31:30]);
        bad   = !instr && ch >= ND;
        is_wr = !instr && wstrb != 4'h0;
        total = is_wr ? r + 1 : r + v + 2;
        tmo   = !bad && total >= TO;
        if (bad) begin
            vend = 0; done_c = 1;
        end else if (tmo) begin
            vend = (r + 1 < TO) ? r + 1 : TO; done_c = TO + 1;
        end else begin
            vend = r + 1; done_c = total + 1;
        end
        exp_addr   = instr ? (boot ? (addr & 32'h7fff_ffff) : (addr | 32'h8000_0000)) : addr;
        prev_rdata = m_rdata;
        if (bad || tmo) begin
            m_rdata = '1;
            m_err   = 1'b1;
        end else if (!is_wr) begin
            m_rdata = resp;
        end

        cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = addr;
        cpu_wdata = wdata; cpu_wstrb = wstrb;
        @(negedge clk);
        cpu_valid = 1'b0;
        cpu_addr  = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom);
        boot      = 1'($urandom);

        for (int c = 1; c <= done_c + 1; c++) begin
            check("ibus_valid", ibus_valid, !bad && instr && c <= vend);
            check("dbus_valid", dbus_valid,
                  (!bad && !instr && c <= vend) ? (3'b001 << ch) : 3'b000);
            check("cpu_ready", cpu_ready, c == done_c);
            if (c == 1 && !bad && instr) begin
                check("ibus_addr", ibus_addr, exp_addr);
                check("ibus_wdata_wstrb", {ibus_wdata, ibus_wstrb}, '0);
            end
            if (c == 1 && !bad && !instr) begin
                check("dbus_addr", dbus_addr, {ND{addr}});
                check("dbus_wdata", dbus_wdata, {ND{wdata}});
                check("dbus_wstrb", dbus_wstrb, {ND{wstrb}});
            end
            if (c < done_c) check("rdata_pending", cpu_rdata, prev_rdata);
            if (c == done_c) begin
                check("rdata_done", cpu_rdata, m_rdata);
                check("err_done", err, m_err);
            end

            if (hold && !is_wr && !tmo && c == r + 2) begin
                cke = 1'b0;
                if (instr) begin ibus_rvalid = 1'b1; ibus_rdata = ~resp; end
                else begin dbus_rvalid[ch] = 1'b1; dbus_rdata[ch*DW +: DW] = ~resp; end
                repeat (4) begin
                    @(negedge clk);
                    check("frozen_valid", {ibus_valid, dbus_valid}, '0);
                    check("frozen_ready", cpu_ready, 1'b0);
                    check("frozen_rdata", cpu_rdata, prev_rdata);
                end
                cke = 1'b1;
            end

            rv  = (!is_wr && c == r + 2 + v) || (spur && c == 1);
            rdv = (spur && c == 1) ? 32'hBAD0_BAD0 : resp;
            ibus_ready  = instr ? (c == r + 1) : 1'b1;
            ibus_rvalid = instr ? rv : 1'b1;
            ibus_rdata  = instr ? rdv : ~resp;
            for (int k = 0; k < ND; k++) begin
                dbus_ready[k]            = (!instr && k == ch) ? (c == r + 1) : 1'b1;
                dbus_rvalid[k]           = (!instr && k == ch) ? rv : 1'b1;
                dbus_rdata[k*DW +: DW]   = (!instr && k == ch) ? rdv : ~resp;
            end
            if (c <= done_c) @(negedge clk);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic          ins;
        logic [3:0]    ws;

        repeat (2) @(negedge clk);
        check("reset_ready", cpu_ready, 1'b0);
        check("reset_rdata_err", {cpu_rdata, err}, '0);
        check("reset_valids", {ibus_valid, dbus_valid}, '0);
        check("reset_addr", {ibus_addr, dbus_addr}, '0);
        arst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases.
        run_txn(0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 0, 0);
        run_txn(0, 32'h8000_0004, 32'h1234_5678, 4'b0011, 5, 0, 32'h0, 0, 0);
        run_txn(0, 32'h4000_0008, 32'hCAFE_F00D, 4'b1111, 0, 0, 32'h0, 0, 0);
        boot = 1'b1;
        run_txn(1, 32'h8000_0100, 32'hFFFF_FFFF, 4'hF, 1, 1, 32'h0000_0013, 0, 0);
        boot = 1'b0;
        run_txn(1, 32'h0000_0200, 32'h0, 4'h0, 0, 2, 32'h0000_0093, 0, 0);
        run_txn(0, 32'h4000_0040, 32'h0, 4'h0, 2, 3, 32'h1111_2222, 1, 0);
        run_txn(0, 32'h8000_0080, 32'h0, 4'h0, 1, 0, 32'h3333_4444, 0, 1);
        run_txn(0, 32'h0000_0100, 32'h0, 4'h0, 12, 0, 32'h5555_6666, 0, 0);
        run_txn(0, 32'h4000_0100, 32'h0, 4'h0, 13, 0, 32'h7777_8888, 0, 0);
        run_txn(0, 32'hC000_0000, 32'h0, 4'hF, 0, 0, 32'h0, 0, 0);
        run_txn(0, 32'h0000_0020, 32'h0, 4'h0, 20, 0, 32'h9999_AAAA, 0, 0);

        // Randomized traffic; err stays sticky throughout.
        for (int i = 0; i < 24; i++) begin
            ins = ($urandom_range(0, 3) == 0);
            a   = $urandom;
            if (!ins) a[31:30] = 2'($urandom_range(0, ND - 1));
            ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            run_txn(ins, a, $urandom, ws, $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        // Reset while a read is waiting for rvalid.
        cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h0000_0010; cpu_wstrb = 4'h0;
        ibus_ready = 1'b0; ibus_rvalid = 1'b0;
        dbus_ready = 3'b000; dbus_rvalid = 3'b000;
        @(negedge clk);
        cpu_valid  = 1'b0;
        dbus_ready = 3'b001;
        @(negedge clk);
        dbus_ready = 3'b000;
        check("rst_pre_resp_valid", dbus_valid, 3'b000);
        #2 arst_n = 1'b0;
        #1;
        check("rst_async_ready", cpu_ready, 1'b0);
        check("rst_async_rdata_err", {cpu_rdata, err}, '0);
        check("rst_async_valids", {ibus_valid, dbus_valid}, '0);
        check("rst_async_addr", {ibus_addr, dbus_addr}, '0);
        @(negedge clk);
        arst_n = 1'b1;
        dbus_rvalid = 3'b001;
        dbus_rdata  = {ND{32'hABCD_EF01}};
        repeat (4) begin
            @(negedge clk);
            check("rst_late_rvalid_ready", cpu_ready, 1'b0);
            check("rst_late_rvalid_valids", {ibus_valid, dbus_valid}, '0);
            check("rst_late_rvalid_rdata", cpu_rdata, '0);
        end
        dbus_rvalid = 3'b000;
        m_rdata = '0;
        m_err   = 1'b0;
        run_txn(0, 32'h4000_0004, 32'h0, 4'h0, 1, 1, 32'h0BAD_F00D, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
